// File: rtl/adc_pkg.sv
// Shared constants, FSM state type and command encoding for the SPI ADC sampler.
package adc_pkg;

  localparam int DATA_W_DEF     = 10;
  localparam int FRAME_BITS     = 16;
  localparam int CMD_BITS       = 4;
  localparam int DATA_FIRST_BIT = 6;

  // Command bits 1..4 sent MSB first: start, single-ended, channel, MSB-first
  localparam logic CMD_START = 1'b1;
  localparam logic CMD_SGL   = 1'b1;
  localparam logic CMD_MSBF  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    DONE
  } state_t;

  // mosi value for frame bit k (1-based); everything past the command is 0
  function automatic logic cmd_bit(input logic [4:0] k, input logic odd);
    logic b;
    case (k)
      5'd1:    b = CMD_START;
      5'd2:    b = CMD_SGL;
      5'd3:    b = odd;
      5'd4:    b = CMD_MSBF;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// SCLK half-period divider: rise/fall strobes and 1-based bit index while enabled.
module sclk_tick_gen
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en,
  output logic       rise,
  output logic       fall,
  output logic [4:0] bit_idx
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(FRAME_BITS);

  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic          high;
  logic          half_end;

  // rise/fall name the edge at which sclk changes, i.e. the last cycle of a half
  assign half_end = en && (div_cnt == DW'(CLK_DIV - 1));
  assign rise     = half_end && !high;
  assign fall     = half_end && high;
  assign bit_idx  = 5'(bit_cnt) + 5'd1;

  // Half-period counter; restarts on the low half of bit 1 whenever disabled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      high    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      high    <= 1'b0;
    end else if (half_end) begin
      div_cnt <= '0;
      high    <= !high;
      if (high) bit_cnt <= bit_cnt + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_spi_sampler.sv
// Periodic MCP3002-style SPI ADC reader (mode 0) producing one sample per period.
module adc_spi_sampler
  import adc_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DIV = 200,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              channel_i,
  input  logic              miso_i,
  output logic              cs_n_o,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic [DATA_W-1:0] sample_o,
  output logic              sample_valid_o,
  output logic              busy_o,
  output logic              overrun_o
);

  localparam int DW            = $clog2(CLK_DIV);
  localparam int PW            = $clog2(SAMPLE_DIV);
  localparam int DATA_LAST_BIT = DATA_FIRST_BIT + DATA_W - 1;

  state_t            state, next_state;
  logic [DW-1:0]     st_cnt;
  logic [PW-1:0]     per_cnt;
  logic              tick, start, st_done, last_fall;
  logic              rise, fall;
  logic [4:0]        bit_idx;
  logic              ch_q;
  logic [DATA_W-1:0] shreg;
  logic              cs_n_d, busy_d, valid_d;

  // Sample period counter; parked at 0 while disabled so enable gives an immediate tick
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                            per_cnt <= '0;
    else if (!enable_i || per_cnt == PW'(SAMPLE_DIV - 1)) per_cnt <= '0;
    else                                                  per_cnt <= per_cnt + 1'b1;
  end

  assign tick      = enable_i && (per_cnt == '0);
  assign start     = (state == IDLE) && tick;
  assign st_done   = (st_cnt == DW'(CLK_DIV - 1));
  assign last_fall = fall && (bit_idx == 5'(FRAME_BITS));

  sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en      (state == SHIFT),
    .rise    (rise),
    .fall    (fall),
    .bit_idx (bit_idx)
  );

  // State register with per-state dwell counter (used by CS_SETUP / CS_HOLD)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      st_cnt <= '0;
    end else begin
      state  <= next_state;
      st_cnt <= (next_state != state) ? '0 : st_cnt + 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (tick)      next_state = CS_SETUP;
      CS_SETUP: if (st_done)   next_state = SHIFT;
      SHIFT:    if (last_fall) next_state = CS_HOLD;
      CS_HOLD:  if (st_done)   next_state = DONE;
      DONE:                    next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  // Output decode from next state so the registered pins line up with the state
  always_comb begin
    cs_n_d  = 1'b1;
    busy_d  = 1'b0;
    valid_d = 1'b0;
    case (next_state)
      CS_SETUP, SHIFT: begin cs_n_d = 1'b0; busy_d = 1'b1; end
      CS_HOLD:         busy_d  = 1'b1;
      DONE:            valid_d = 1'b1;
      default:         ;
    endcase
  end

  // Registered pins and datapath: command out on sclk falls, data in on sclk rises
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cs_n_o         <= 1'b1;
      sclk_o         <= 1'b0;
      mosi_o         <= 1'b0;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      busy_o         <= 1'b0;
      overrun_o      <= 1'b0;
      ch_q           <= 1'b0;
      shreg          <= '0;
    end else begin
      cs_n_o         <= cs_n_d;
      busy_o         <= busy_d;
      sample_valid_o <= valid_d;
      overrun_o      <= tick && (state != IDLE);

      if (rise)                               sclk_o <= 1'b1;
      else if (fall || next_state != SHIFT)   sclk_o <= 1'b0;

      if (start) begin
        ch_q   <= channel_i;
        mosi_o <= cmd_bit(5'd1, channel_i);
        shreg  <= '0;
      end else begin
        if (fall) mosi_o <= cmd_bit(bit_idx + 5'd1, ch_q);
        if (rise && bit_idx >= 5'(DATA_FIRST_BIT) && bit_idx <= 5'(DATA_LAST_BIT))
          shreg <= {shreg[DATA_W-2:0], miso_i};
      end

      if (valid_d) sample_o <= shreg;
    end
  end

endmodule
